// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and small decode helpers used by fetch and decode.
package mips_pkg;

    // Instruction field positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int TGT_HI = 25;
    localparam int TGT_LO = 0;

    // Opcodes of interest at fetch time
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;

    // Coarse instruction format classes
    typedef enum logic [1:0] {
        ITYPE_R = 2'd0,
        ITYPE_J = 2'd1,
        ITYPE_I = 2'd2
    } itype_e;

    // True for J and JAL, whose target is resolvable from the word alone
    function automatic logic is_jump(input logic [31:0] w);
        return (w[OPC_HI:OPC_LO] == OP_J) || (w[OPC_HI:OPC_LO] == OP_JAL);
    endfunction

    // Classify a word into R/J/I format
    function automatic itype_e predecode(input logic [31:0] w);
        if (w[OPC_HI:OPC_LO] == OP_RTYPE) begin
            return ITYPE_R;
        end else if (is_jump(w)) begin
            return ITYPE_J;
        end
        return ITYPE_I;
    endfunction

endpackage

// File: rtl/fetch_unit_inst_fifo.sv
// Small synchronous FIFO buffering fetched words for decode.
// The head output holds the last presented entry while the FIFO is empty.
module inst_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             head,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Qualify handshakes: no pop from empty, no push into full unless it is also popping
    always_comb begin
        valid   = (count != '0);
        do_pop  = pop && valid;
        do_push = push && ((count != CW'(DEPTH)) || do_pop);
        head    = valid ? mem[rd_ptr] : last;
    end

    // Storage, pointers, occupancy and held head value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            last   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (valid) begin
                last <= mem[rd_ptr];
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction memory port, J/JAL resolution,
// downstream redirect and a small buffer toward decode.
// Optional: define FETCH_PREDECODE_EN to add the registered inst_type output.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd128,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        stop,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] memIn,
    input  logic [31:0] memOut,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        busy
`ifdef FETCH_PREDECODE_EN
    ,
    output logic [1:0]  inst_type
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
`ifdef FETCH_PREDECODE_EN
    localparam int EW = 66;
`else
    localparam int EW = 64;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e          state;
    state_e          state_nxt;
    logic [31:0]     pc;
    logic [31:0]     pc4;
    logic [31:0]     nxt;
    logic            pop;
    logic            fire;
    logic [CW-1:0]   count;
    logic [EW-1:0]   din;
    logic [EW-1:0]   head;

    assign write   = 1'b0;
    assign memIn   = '0;
    assign address = pc;
    assign read    = fire;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, fetch qualification and next-PC selection
    always_comb begin
        state_nxt = state;
        busy      = (state == RUN);
        pop       = inst_valid && inst_ready;
        fire      = 1'b0;
        pc4       = pc + 32'd4;
        nxt       = pc4;
        case (state)
            IDLE: if (go)   state_nxt = RUN;
            RUN:  if (stop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state == RUN && !redirect && ((count != CW'(DEPTH)) || pop)) begin
            fire = 1'b1;
        end
        if (is_jump(memOut)) begin
            nxt = {pc4[31:28], memOut[TGT_HI:TGT_LO], 2'b00};
        end
    end

    // Program counter: redirect wins, then sequential/jump advance on fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc & ~32'd3;
        end else if (fire) begin
            pc <= nxt;
        end
    end

`ifdef FETCH_PREDECODE_EN
    assign din       = {predecode(memOut), pc, memOut};
    assign inst_type = head[65:64];
`else
    assign din = {pc, memOut};
`endif
    assign inst_pc = head[63:32];
    assign inst    = head[31:0];

    // Redirect flushes the buffer; the fifo ignores pop while flushing
    inst_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fire),
        .pop   (pop),
        .flush (redirect),
        .din   (din),
        .head  (head),
        .valid (inst_valid),
        .count (count)
    );

endmodule
